// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder family.
package serial_add_pkg;

    localparam int SERIAL_ADD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_add_bit.sv
// Combinational 1-bit full adder built from two half-adder stages.
module full_add_bit (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    logic w_hs1;
    logic w_hc1;
    logic w_hc2;

    assign w_hs1  = i_a ^ i_b;
    assign w_hc1  = i_a & i_b;
    assign o_s    = w_hs1 ^ i_cin;
    assign w_hc2  = w_hs1 & i_cin;
    assign o_cout = w_hc1 | w_hc2;

endmodule

// File: rtl/serial_add_unit.sv
// Bit-serial ripple adder: one full-adder cell plus carry flop, LSB first,
// with valid/ready handshakes on operands and result.
module serial_add_unit
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  ONE  = CW'(1);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_sum_sr;
    logic             r_carry;
    logic [CW-1:0]    r_count;
    logic             w_s;
    logic             w_c;
    logic             w_accept;
    logic             w_shift;

    full_add_bit u_fa (
        .i_a    (r_a_sr[0]),
        .i_b    (r_b_sr[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    // Next-state and datapath-enable decode
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_shift      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = SHIFT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            SHIFT: begin
                w_shift = 1'b1;
                if (r_count == LAST) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register, operand/sum shift registers, carry flop and bit counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_sum_sr <= '0;
            r_carry  <= 1'b0;
            r_count  <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_a_sr  <= a;
                r_b_sr  <= b;
                r_carry <= cin;
                r_count <= '0;
            end else if (w_shift) begin
                r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
                r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
                r_sum_sr <= {w_s, r_sum_sr[WIDTH-1:1]};
                r_carry  <= w_c;
                r_count  <= r_count + ONE;
            end
        end
    end

    // in_ready is gated by rst so no operand is offered during reset
    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign busy      = (r_state != IDLE);
    assign sum       = r_sum_sr;
    assign cout      = r_carry;

endmodule

// File: doc/serial_add_unit.md
Name: serial_add_unit

Overview:
Bit-serial ripple adder, the additive counterpart to the team's subtractor blocks. It accepts two WIDTH-bit operands plus carry-in through a valid/ready handshake. It computes the sum LSB-first, one bit per clock, through a single full-adder cell and a carry flop, then returns sum and carry-out through a second valid/ready handshake. It is the area-minimal adder option for datapaths that can tolerate WIDTH-cycle latency.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand set a/b/cin is valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  augend.
- b  input  WIDTH  addend.
- cin  input  1  carry-in.
- out_valid  output  1  sum/cout are valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  a + b + cin, modulo 2^WIDTH.
- cout  output  1  carry-out of the WIDTH-bit add.
- busy  output  1  high in SHIFT or DONE.

Behaviour:
- Reset, sampled at the clk edge while rst=1:
  - state<=IDLE; out_valid=0, sum=0, cout=0, busy=0; internal shift registers and counter cleared.
  - in_ready=0 while rst=1.
- rst has priority over every other event, including a handshake in the same cycle and a computation already in progress.
- State IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: capture a and b into shift registers, carry<=cin, count<=0, go to SHIFT.
  - Operand values are don't-care when in_valid=0.
- State SHIFT, one result bit per cycle:
  - s = a_sr[0]^b_sr[0]^carry.
  - carry <= majority(a_sr[0], b_sr[0], carry).
  - sum_sr <= {s, sum_sr[WIDTH-1:1]}; a_sr and b_sr shift right by 1; count++.
  - When count==WIDTH-1, go to DONE. SHIFT therefore lasts exactly WIDTH cycles.
  - in_ready=0 throughout SHIFT; in_valid is ignored.
- State DONE:
  - out_valid=1; sum=sum_sr and cout=carry, both held stable until handshake.
  - On out_ready=1: go to IDLE at that edge, out_valid drops next cycle.
  - in_ready=0 in DONE; there is no same-cycle result/operand overlap.
- Latency: operands accepted at edge k; out_valid is high from edge k+WIDTH.
- Throughput: with out_ready held at 1, at most one operation per WIDTH+2 cycles.
- Arithmetic: full result is {cout, sum} = a + b + cin, WIDTH+1 bits, unsigned. No overflow flag; signed users derive it externally.
- Boundaries:
  - out_ready asserted outside DONE has no effect.
  - out_ready held low keeps the block in DONE indefinitely with sum/cout frozen.
  - Reset mid-SHIFT or in DONE discards the result: out_valid never rises for that operation.
  - Count width is $clog2(WIDTH); no wrap beyond WIDTH-1 is possible.

Decomposition:
- Package serial_add_pkg holds:
  - the state typedef (IDLE, SHIFT, DONE; 2-bit enum);
  - the default width constant SERIAL_ADD_WIDTH=8.
- Sub-module full_add_bit: combinational 1-bit full adder (a, b, cin -> s, cout), built from two half-adder stages. It is instantiated once in serial_add_unit and is reusable by the serial subtractor.

Test Plan:
- WIDTH=8, a=8'h0F, b=8'h01, cin=0, out_ready=1:
  - in_ready falls the cycle after acceptance;
  - out_valid rises exactly 8 cycles after the accept edge;
  - sum=8'h10, cout=0.
- Carry ripple across all bits and full saturation (WIDTH=8):
  - a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1;
  - a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Backpressure:
  - hold out_ready=0 for 5 cycles after out_valid; sum/cout stay constant and in_valid pulses are ignored (in_ready=0);
  - raising out_ready returns the block to IDLE next cycle;
  - the next operation, 8'h22+8'h11 cin=0, yields 8'h33.
- Reset mid-operation:
  - assert rst on the 3rd SHIFT cycle for 1 cycle;
  - required: out_valid stays 0, busy=0 and in_ready=1 the cycle after rst falls;
  - a fresh operation 8'h80+8'h80 yields sum=8'h00, cout=1.
- Exhaustive, WIDTH=2:
  - all 32 combinations of a, b, cin, with randomized out_ready stalls;
  - every {cout, sum} equals a+b+cin;
  - every result arrives exactly 2 cycles after acceptance when out_ready=1.
- Back-to-back: in_valid held high with out_ready=1 -> new accepts spaced exactly WIDTH+2 cycles apart; no operand is lost or duplicated.
